// File: rtl/vfu_arb_pkg.sv
// Shared types and helpers for the VFU slot arbiter.
// The request bundle layout is carried opaquely by the arbiter; the struct
// exists so producers and consumers agree on the packing and its width.
package vfu_arb_pkg;

  typedef struct packed {
    logic [3:0][32:0] src;          // four 33b source operands
    logic [7:0]       opcode;
    logic [15:0]      mask;
    logic [7:0]       ctrl_flags;
    logic [4:0]       shifter_size;
    logic [11:0]      pop_init;
    logic [10:0]      indices;
    logic [2:0]       rnd_mode;
    logic [14:0]      tag;
  } vfu_slot_req_t;

  // Default payload width follows the bundle (210 bits).
  localparam int VFU_PAYLOAD_W = $bits(vfu_slot_req_t);

  // Channel index width; a single requester still needs one bit.
  function automatic int vfu_idx_w(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vfu_slot_arbiter_rr_pick.sv
// Combinational cyclic first-one finder: scans valid from ptr upward,
// wrapping at NUM_IN, and returns the first hit as one-hot and index.
module rr_pick #(
  parameter int NUM_IN = 4,
  parameter int IDX_W  = 2
) (
  input  logic [NUM_IN-1:0] valid,
  input  logic [IDX_W-1:0]  ptr,
  output logic [NUM_IN-1:0] grant,
  output logic [IDX_W-1:0]  idx,
  output logic              any_vld
);

  logic [IDX_W-1:0] cand;

  // Walk the candidates in priority order; the first valid one wins.
  always_comb begin
    grant   = '0;
    idx     = '0;
    any_vld = 1'b0;
    cand    = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      cand = IDX_W'((int'(ptr) + k) % NUM_IN);
      if (!any_vld && valid[cand]) begin
        grant[cand] = 1'b1;
        idx         = cand;
        any_vld     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/vfu_slot_arbiter.sv
// Round-robin arbiter feeding a shared VFU port through a registered stage.
// Build option VFU_SLOT_ARB_SKID_EN: when defined, the output stage is a
// 2-entry skid FIFO so in_ready depends only on registered state; otherwise
// it is a single pipeline register with a combinational ready path.
module vfu_slot_arbiter
  import vfu_arb_pkg::*;
#(
  parameter int NUM_IN    = 4,
  parameter int PAYLOAD_W = VFU_PAYLOAD_W,
  parameter int IDX_W     = vfu_idx_w(NUM_IN)
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NUM_IN-1:0]         in_valid,
  output logic [NUM_IN-1:0]         in_ready,
  input  logic [NUM_IN*PAYLOAD_W-1:0] in_bits,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PAYLOAD_W-1:0]      out_bits,
  output logic [IDX_W-1:0]          out_chosen
);

  logic [IDX_W-1:0]     rr_ptr;
  logic [NUM_IN-1:0]    grant;
  logic [IDX_W-1:0]     pick_idx;
  logic                 any_vld;
  logic                 can_accept;
  logic                 accept;
  logic [PAYLOAD_W-1:0] slot_bits [NUM_IN];
  logic [PAYLOAD_W-1:0] sel_bits;

  rr_pick #(
    .NUM_IN (NUM_IN),
    .IDX_W  (IDX_W)
  ) u_pick (
    .valid   (in_valid),
    .ptr     (rr_ptr),
    .grant   (grant),
    .idx     (pick_idx),
    .any_vld (any_vld)
  );

  for (genvar i = 0; i < NUM_IN; i++) begin : g_slot
    assign slot_bits[i] = in_bits[i*PAYLOAD_W +: PAYLOAD_W];
  end

  assign sel_bits = slot_bits[pick_idx];

  // Reset gates ready directly so nothing is taken while reset is held.
  assign accept   = reset && can_accept && any_vld;
  assign in_ready = accept ? grant : '0;

  // Priority moves just past the winner, and only on an actual accept.
  always_ff @(posedge clock) begin
    if (!reset)
      rr_ptr <= '0;
    else if (accept)
      rr_ptr <= (pick_idx == IDX_W'(NUM_IN-1)) ? '0 : pick_idx + IDX_W'(1);
  end

`ifdef VFU_SLOT_ARB_SKID_EN

  logic [PAYLOAD_W-1:0] ent_bits [2];
  logic [IDX_W-1:0]     ent_idx  [2];
  logic                 wr_sel;
  logic                 rd_sel;
  logic [1:0]           cnt;
  logic                 pop;

  // Ready comes from the registered count only; a full FIFO refuses for the
  // cycle even if the VFU drains it at the same edge.
  assign can_accept = (cnt != 2'd2);
  assign out_valid  = (cnt != 2'd0);
  assign pop        = out_valid && out_ready;
  assign out_bits   = ent_bits[rd_sel];
  assign out_chosen = ent_idx[rd_sel];

  // Two-entry ring; push and pop may coincide, keeping occupancy.
  always_ff @(posedge clock) begin
    if (!reset) begin
      cnt    <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      for (int e = 0; e < 2; e++) begin
        ent_bits[e] <= '0;
        ent_idx[e]  <= '0;
      end
    end else begin
      if (accept) begin
        ent_bits[wr_sel] <= sel_bits;
        ent_idx[wr_sel]  <= pick_idx;
        wr_sel           <= ~wr_sel;
      end
      if (pop)
        rd_sel <= ~rd_sel;
      cnt <= cnt + {1'b0, accept} - {1'b0, pop};
    end
  end

`else

  logic                 vld_q;
  logic [PAYLOAD_W-1:0] bits_q;
  logic [IDX_W-1:0]     idx_q;

  // Single register: refill whenever it is empty or being drained this cycle.
  assign can_accept = !vld_q || out_ready;
  assign out_valid  = vld_q;
  assign out_bits   = bits_q;
  assign out_chosen = idx_q;

  // Load on accept; otherwise clear valid once the VFU has taken the entry.
  always_ff @(posedge clock) begin
    if (!reset) begin
      vld_q  <= 1'b0;
      bits_q <= '0;
      idx_q  <= '0;
    end else if (accept) begin
      vld_q  <= 1'b1;
      bits_q <= sel_bits;
      idx_q  <= pick_idx;
    end else if (out_ready) begin
      vld_q  <= 1'b0;
    end
  end

`endif

endmodule
